// File: rtl/dma_prog_if.sv
// dma_prog_if: CPU programming interface for a 4-channel DMA controller.
// Latency: CPU writes commit on the clock edge that sees the strobe's trailing
//   edge; reads are combinational from A. Backpressure: none, HLDA blocks CPU access.
// Ports: CLK/RESET; CPU bus CS_N, IOR_N, IOW_N, HLDA, A, DB_IN, DB_OUT, DB_OE;
//   engine side dreq, tc_set, upd_*, reload_en; programmed state out to the
//   timing engine (cmd_reg, mode_reg, mask, sw_req, curr_addr, curr_count, byte_ptr).
module dma_prog_if (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS_N,
  input  logic        IOR_N,
  input  logic        IOW_N,
  input  logic        HLDA,
  input  logic [3:0]  A,
  input  logic [7:0]  DB_IN,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  input  logic [3:0]  dreq,
  input  logic [3:0]  tc_set,
  input  logic        upd_en,
  input  logic [1:0]  upd_ch,
  input  logic [15:0] upd_addr,
  input  logic [15:0] upd_count,
  input  logic        reload_en,
  output logic [7:0]  cmd_reg,
  output logic [31:0] mode_reg,
  output logic [3:0]  mask,
  output logic [3:0]  sw_req,
  output logic [63:0] curr_addr,
  output logic [63:0] curr_count,
  output logic        byte_ptr
);

  logic        r_rd_act, r_wr_act;
  logic        r_blk;
  logic [3:0]  r_rd_a, r_wr_a;
  logic [7:0]  r_wr_d;
  logic [7:0]  r_cmd;
  logic [7:0]  r_mode [4];
  logic [3:0]  r_mask, r_sw_req, r_tc;
  logic [15:0] r_base_addr  [4];
  logic [15:0] r_base_count [4];
  logic [15:0] r_curr_addr  [4];
  logic [15:0] r_curr_count [4];
  logic        r_byte_ptr;
  logic [7:0]  r_temp;

  logic        w_rd_raw, w_wr_raw, w_strobe_raw;
  logic        w_rd_act, w_wr_act;
  logic        w_wr_commit, w_rd_end, w_stat_rd_end, w_mclr, w_cpu_ch_wr;
  logic [1:0]  w_ch;
  logic [3:0]  w_tc_next, w_sw_next;
  logic [15:0] w_sel;
  logic [7:0]  w_db_out;

  assign w_rd_raw     = ~CS_N & ~IOR_N & ~HLDA;
  assign w_wr_raw     = ~CS_N & ~IOW_N & ~HLDA;
  assign w_strobe_raw = ~CS_N & (~IOR_N | ~IOW_N);

  // r_blk swallows a strobe that was interrupted by RESET or HLDA until the
  // CPU releases it, so a stale access can never commit afterwards.
  assign w_rd_act = w_rd_raw & ~r_blk;
  assign w_wr_act = w_wr_raw & ~r_blk;

  // Trailing edge only counts when HLDA is low; an HLDA-induced drop aborts.
  assign w_wr_commit   = r_wr_act & ~w_wr_act & ~HLDA;
  assign w_rd_end      = r_rd_act & ~w_rd_act & ~HLDA;
  assign w_stat_rd_end = w_rd_end & (r_rd_a == 4'h8);
  assign w_mclr        = w_wr_commit & (r_wr_a == 4'hD);
  assign w_ch          = r_wr_a[2:1];
  assign w_cpu_ch_wr   = w_wr_commit & ~r_wr_a[3];

  // tc_set is applied after the clears so a coincident pulse is not lost.
  assign w_tc_next = ((w_stat_rd_end | w_mclr) ? 4'h0 : r_tc) | tc_set;

  always_comb begin
    w_sw_next = r_sw_req;
    if (w_wr_commit && r_wr_a == 4'h9) w_sw_next[r_wr_d[1:0]] = r_wr_d[2];
    if (w_mclr) w_sw_next = 4'h0;
    w_sw_next = w_sw_next & ~tc_set;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rd_act   <= 1'b0;
      r_wr_act   <= 1'b0;
      r_blk      <= 1'b1;
      r_rd_a     <= 4'h0;
      r_wr_a     <= 4'h0;
      r_wr_d     <= 8'h00;
      r_cmd      <= 8'h00;
      r_mask     <= 4'hF;
      r_sw_req   <= 4'h0;
      r_tc       <= 4'h0;
      r_byte_ptr <= 1'b0;
      r_temp     <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        r_mode[i]       <= 8'h00;
        r_base_addr[i]  <= 16'h0000;
        r_base_count[i] <= 16'h0000;
        r_curr_addr[i]  <= 16'h0000;
        r_curr_count[i] <= 16'h0000;
      end
    end else begin
      r_rd_act <= w_rd_act;
      r_wr_act <= w_wr_act;
      r_blk    <= (r_blk | HLDA) & w_strobe_raw;
      if (w_wr_act) begin
        r_wr_a <= A;
        r_wr_d <= DB_IN;
      end
      if (w_rd_act) r_rd_a <= A;
      r_tc     <= w_tc_next;
      r_sw_req <= w_sw_next;

      // Engine write-back is dropped entirely when the CPU commits to the
      // same channel this cycle; reload takes precedence over upd_en.
      if (!(w_cpu_ch_wr && w_ch == upd_ch)) begin
        if (reload_en) begin
          r_curr_addr[upd_ch]  <= r_base_addr[upd_ch];
          r_curr_count[upd_ch] <= r_base_count[upd_ch];
        end else if (upd_en) begin
          r_curr_addr[upd_ch]  <= upd_addr;
          r_curr_count[upd_ch] <= upd_count;
        end
      end

      if (w_wr_commit) begin
        if (!r_wr_a[3]) begin
          // Byte lanes written independently: no carry between halves.
          if (!r_wr_a[0]) begin
            if (r_byte_ptr) begin
              r_base_addr[w_ch][15:8] <= r_wr_d;
              r_curr_addr[w_ch][15:8] <= r_wr_d;
            end else begin
              r_base_addr[w_ch][7:0]  <= r_wr_d;
              r_curr_addr[w_ch][7:0]  <= r_wr_d;
            end
          end else begin
            if (r_byte_ptr) begin
              r_base_count[w_ch][15:8] <= r_wr_d;
              r_curr_count[w_ch][15:8] <= r_wr_d;
            end else begin
              r_base_count[w_ch][7:0]  <= r_wr_d;
              r_curr_count[w_ch][7:0]  <= r_wr_d;
            end
          end
          r_byte_ptr <= ~r_byte_ptr;
        end else begin
          case (r_wr_a[2:0])
            3'd0: r_cmd <= r_wr_d;
            3'd2: r_mask[r_wr_d[1:0]] <= r_wr_d[2];
            3'd3: r_mode[r_wr_d[1:0]] <= r_wr_d;
            3'd4: r_byte_ptr <= 1'b0;
            3'd5: begin
              r_cmd      <= 8'h00;
              r_temp     <= 8'h00;
              r_byte_ptr <= 1'b0;
              r_mask     <= 4'hF;
            end
            3'd6: r_mask <= 4'h0;
            3'd7: r_mask <= r_wr_d[3:0];
            default: ;
          endcase
        end
      end else if (w_rd_end && !r_rd_a[3]) begin
        r_byte_ptr <= ~r_byte_ptr;
      end
    end
  end

  always_comb begin
    w_sel    = A[0] ? r_curr_count[A[2:1]] : r_curr_addr[A[2:1]];
    w_db_out = 8'h00;
    if (!RESET) begin
      if (!A[3])            w_db_out = r_byte_ptr ? w_sel[15:8] : w_sel[7:0];
      else if (A == 4'h8)   w_db_out = {dreq | r_sw_req, r_tc};
      else if (A == 4'hD)   w_db_out = r_temp;
    end
  end

  assign DB_OUT     = w_db_out;
  assign DB_OE      = w_rd_raw & ~RESET;
  assign cmd_reg    = r_cmd;
  assign mode_reg   = {r_mode[3], r_mode[2], r_mode[1], r_mode[0]};
  assign mask       = r_mask;
  assign sw_req     = r_sw_req;
  assign curr_addr  = {r_curr_addr[3], r_curr_addr[2], r_curr_addr[1], r_curr_addr[0]};
  assign curr_count = {r_curr_count[3], r_curr_count[2], r_curr_count[1], r_curr_count[0]};
  assign byte_ptr   = r_byte_ptr;

endmodule
